// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV64I format/opcode constants and FIFO sizing
package riscv_pkg;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef logic [31:0] word_t;
endpackage

// File: rtl/instruction_encoder_if.sv
// rtl/instruction_encoder_if.sv - field input / instruction output handshake bundle
interface instruction_encoder_if
  import riscv_pkg::*;
#(
  parameter int PTR_W = FIFO_PTR_W
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       fmt;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  word_t            instruction;
  logic [PTR_W:0]   count;
  logic             err_illegal;

  modport master (
    output in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    input  in_ready, out_valid, instruction, count, err_illegal
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    output in_ready, out_valid, instruction, count, err_illegal
  );
endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - DEPTH x 32 synchronous FIFO with occupancy count
module instr_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = FIFO_PTR_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  word_t          wdata,
  output word_t          rdata,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);
  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Gate the head so the output reads zero whenever nothing is buffered.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs decoded RV64I fields into 32-bit words behind a FIFO
module instruction_encoder
  import riscv_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = FIFO_PTR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_encoder_if.slave  bus
);
  logic  full;
  logic  empty;
  logic  legal;
  logic  accept;
  logic  push;
  logic  pop;
  logic  err_q;
  word_t enc_word;
  word_t head;

  function automatic word_t encode(
    input logic [2:0]  fmt,
    input logic [6:0]  opcode,
    input logic [4:0]  rd,
    input logic [2:0]  funct3,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [6:0]  funct7,
    input logic [31:0] imm
  );
    case (fmt)
      FMT_R:   return {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   return {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   return {imm[31:12], rd, opcode};
      FMT_J:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: return '0;
    endcase
  endfunction

  assign enc_word = encode(bus.fmt, bus.opcode, bus.rd, bus.funct3,
                           bus.rs1, bus.rs2, bus.funct7, bus.imm);
  assign legal    = (bus.fmt <= FMT_J);
  // Illegal formats still complete the handshake; they are simply not stored.
  assign accept   = bus.in_valid && !full;
  assign push     = accept && legal;
  assign pop      = bus.out_ready && !empty;

  instr_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (enc_word),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (bus.count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= accept && !legal;
  end

  assign bus.in_ready    = !full;
  assign bus.out_valid   = !empty;
  assign bus.instruction = head;
  assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - self-checking bench for instruction_encoder
module tb_instruction_encoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  instruction_encoder_if #(.PTR_W(2)) bus ();

  instruction_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] ref_enc(input logic [31:0] f, op, rd, f3, rs1, rs2, f7, imm);
    logic [31:0] regs;
    regs = (rs2 << 20) | (rs1 << 15) | (f3 << 12);
    case (f)
      0: return (f7 << 25) | regs | (rd << 7) | op;
      1: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      2: return (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | op;
      3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | regs
                | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | op;
      4: return (imm & 32'hFFFFF000) | (rd << 7) | op;
      5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | op;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [6:0] f7, input logic [31:0] imm);
    bus.fmt = f; bus.opcode = op; bus.rd = rd; bus.funct3 = f3;
    bus.rs1 = rs1; bus.rs2 = rs2; bus.funct7 = f7; bus.imm = imm;
  endtask

  task automatic rand_fields(input bit allow_illegal);
    logic [2:0] f;
    f = (allow_illegal && ($urandom % 8 == 0)) ? 3'(6 + $urandom % 2) : 3'($urandom % 6);
    set_fields(f, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
               5'($urandom), 7'($urandom), $urandom);
  endtask

  // One clock: check visible state against the model, then advance the model.
  task automatic cycle();
    bit exp_rdy, exp_val, acc, pop_ok, ill;
    logic [31:0] w;
    exp_rdy = (q.size() < 4);
    exp_val = (q.size() != 0);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_val));
    chk("count", 32'(bus.count), q.size());
    chk("instruction", bus.instruction, exp_val ? q[0] : 32'h0);
    acc    = bus.in_valid && exp_rdy;
    pop_ok = bus.out_ready && exp_val;
    ill    = (bus.fmt > 3'd5);
    w = ref_enc(32'(bus.fmt), 32'(bus.opcode), 32'(bus.rd), 32'(bus.funct3),
                32'(bus.rs1), 32'(bus.rs2), 32'(bus.funct7), bus.imm);
    @(posedge clk);
    #1;
    if (pop_ok) void'(q.pop_front());
    if (acc && !ill) q.push_back(w);
    chk("err_illegal", 32'(bus.err_illegal), 32'(acc && ill));
  endtask

  task automatic push_then_pop(input string tag, input logic [31:0] exp_word);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    cycle();
    bus.in_valid = 1'b0;
    chk(tag, bus.instruction, exp_word);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_fields(3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);

    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_instruction", bus.instruction, 32'd0);
    chk("rst_err", 32'(bus.err_illegal), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    set_fields(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    push_then_pop("enc_r", 32'h002081B3);
    set_fields(3'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF);
    push_then_pop("enc_i_addi", 32'hFFF00293);
    set_fields(3'd2, 7'h23, 5'd0, 3'd3, 5'd1, 5'd2, 7'd0, 32'd8);
    push_then_pop("enc_s_sd", 32'h0020B423);
    set_fields(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC);
    push_then_pop("enc_b_beq", 32'hFE208EE3);
    set_fields(3'd4, 7'h37, 5'd7, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
    push_then_pop("enc_u_lui", 32'h123453B7);
    set_fields(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000801);
    push_then_pop("enc_j_jal", 32'h001000EF);

    // Backpressure: four fill the FIFO, fifth waits for space.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_fields(1'b0);
      bus.in_valid = 1'b1;
      cycle();
    end
    chk("bp_count_full", 32'(bus.count), 32'd4);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    rand_fields(1'b0);
    cycle();
    cycle();
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_fifth_pending", 32'(q.size()), 32'd3);
    cycle();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("bp_drained", 32'(bus.count), 32'd0);

    // Illegal format: dropped, one-cycle error pulse.
    bus.out_ready = 1'b0;
    set_fields(3'd6, 7'h33, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'd0);
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("ill_pulse", 32'(bus.err_illegal), 32'd1);
    chk("ill_no_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    chk("ill_pulse_end", 32'(bus.err_illegal), 32'd0);

    for (int i = 0; i < 400; i++) begin
      rand_fields(1'b1);
      bus.in_valid  = ($urandom % 4 != 0);
      bus.out_ready = ($urandom % 2 == 0);
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // Reset mid-stream, asserted away from the clock edge.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_fields(1'b0);
      bus.in_valid = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    chk("mid_count_before", 32'(bus.count), 32'd3);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_count", 32'(bus.count), 32'd0);
    chk("mid_instruction", bus.instruction, 32'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    set_fields(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    push_then_pop("post_rst_word", 32'h002081B3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
